sprite_palette_engine: RTL and testbench

//  Programmable, multi-palette sprite colour lookup with a 2-stage registered pipeline.

---
 rtl/sprite_palette_pkg.sv | 32 +++
 rtl/palette_flash_fsm.sv | 62 ++++++
 rtl/sprite_palette_engine.sv | 131 +++++++++++++
 tb/tb_sprite_palette_engine.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_palette_pkg.sv
// Shared types and the power-on palette table for the sprite colour lookup.
package sprite_palette_pkg;

    localparam int DEF_ENTRIES = 8;

    // Default table entries are 4 bits per channel; wider builds replicate bits.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        FLASH_IDLE,
        FLASH_ON,
        FLASH_OFF
    } flash_state_e;

    localparam rgb_t DEFAULT_PALETTE [DEF_ENTRIES] = '{
        12'h0E0, 12'h000, 12'h877, 12'hDAA,
        12'h910, 12'h080, 12'h544, 12'hEEE
    };

    // Entries beyond the default table come up black.
    function automatic rgb_t default_rgb(input int idx);
        if (idx >= 0 && idx < DEF_ENTRIES) begin
            return DEFAULT_PALETTE[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// Hit-flash sequencer: counts video frames and alternates ON/OFF phases.
module palette_flash_fsm
    import sprite_palette_pkg::*;
#(
    parameter int FLASH_FRAMES = 16,
    parameter int FLASH_PERIOD = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_tick,
    input  logic flash_start,
    output logic flash_on,
    output logic flash_active
);

    localparam logic [7:0] FRAMES_INIT = 8'(FLASH_FRAMES);
    localparam logic [7:0] PERIOD_V    = 8'(FLASH_PERIOD);

    flash_state_e state;
    logic [7:0]   frames_left;
    logic [7:0]   ph;

    // Flash sequencing; a restart beats a same-cycle tick, expiry beats a phase toggle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= FLASH_IDLE;
            frames_left  <= '0;
            ph           <= '0;
            flash_on     <= 1'b0;
            flash_active <= 1'b0;
        end else if (flash_start) begin
            state        <= FLASH_ON;
            frames_left  <= FRAMES_INIT;
            ph           <= '0;
            flash_on     <= 1'b1;
            flash_active <= 1'b1;
        end else if (frame_tick && state != FLASH_IDLE) begin
            if (frames_left == 8'd1) begin
                state        <= FLASH_IDLE;
                frames_left  <= '0;
                ph           <= '0;
                flash_on     <= 1'b0;
                flash_active <= 1'b0;
            end else begin
                frames_left <= frames_left - 8'd1;
                if (ph + 8'd1 == PERIOD_V) begin
                    ph <= '0;
                    if (state == FLASH_ON) begin
                        state    <= FLASH_OFF;
                        flash_on <= 1'b0;
                    end else begin
                        state    <= FLASH_ON;
                        flash_on <= 1'b1;
                    end
                end else begin
                    ph <= ph + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_palette_engine.sv
// Multi-palette sprite colour lookup: writable palettes, transparency key,
// and a frame-timed white hit-flash, in a two-stage registered pipeline.
module sprite_palette_engine
    import sprite_palette_pkg::*;
#(
    parameter int IDX_W        = 3,
    parameter int NUM_PAL      = 4,
    parameter int COLOR_W      = 4,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 16,
    parameter int FLASH_PERIOD = 2,
    localparam int PAL_W       = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1,
    localparam int RGB_W       = 3 * COLOR_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               wr_en,
    input  logic [PAL_W-1:0]   wr_pal,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [RGB_W-1:0]   wr_rgb,
    input  logic               pix_valid_in,
    input  logic [PAL_W-1:0]   pix_pal,
    input  logic [IDX_W-1:0]   pix_idx,
    input  logic               frame_tick,
    input  logic               flash_start,
    output logic               pix_valid_out,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               transparent,
    output logic               flash_active
);

    localparam int ENTRIES = 2 ** IDX_W;

    // Widen a 4-bit default channel to COLOR_W by bit replication.
    function automatic logic [COLOR_W-1:0] scale_ch(input logic [3:0] c);
        logic [COLOR_W-1:0] r;
        for (int b = 0; b < COLOR_W; b++) begin
            r[COLOR_W-1-b] = c[3-(b%4)];
        end
        return r;
    endfunction

    function automatic logic [RGB_W-1:0] default_entry(input int idx);
        rgb_t d;
        d = default_rgb(idx);
        return {scale_ch(d.r), scale_ch(d.g), scale_ch(d.b)};
    endfunction

    // Hit flash turns opaque pixels white; keyed pixels stay see-through.
    function automatic logic [RGB_W-1:0] apply_flash(input logic [RGB_W-1:0] rgb,
                                                     input logic on,
                                                     input logic transp);
        return (on && !transp) ? {RGB_W{1'b1}} : rgb;
    endfunction

    logic [RGB_W-1:0] pal_mem [NUM_PAL][ENTRIES];
    logic [PAL_W-1:0] rd_pal;
    logic [RGB_W-1:0] rd_rgb;
    logic             transp_hit;
    logic             flash_on;

    logic             vld_p1;
    logic [RGB_W-1:0] rgb_p1;
    logic             transp_p1;
    logic [RGB_W-1:0] rgb_p2;

    palette_flash_fsm #(
        .FLASH_FRAMES(FLASH_FRAMES),
        .FLASH_PERIOD(FLASH_PERIOD)
    ) u_flash (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .flash_start (flash_start),
        .flash_on    (flash_on),
        .flash_active(flash_active)
    );

    // Palette storage; out-of-range palette writes are dropped.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PAL; p++) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    pal_mem[p][e] <= default_entry(e);
                end
            end
        end else if (wr_en && (32'(wr_pal) < NUM_PAL)) begin
            pal_mem[wr_pal][wr_idx] <= wr_rgb;
        end
    end

    // Out-of-range palette selects fall back to palette 0.
    assign rd_pal     = (32'(pix_pal) < NUM_PAL) ? pix_pal : '0;
    assign rd_rgb     = pal_mem[rd_pal][pix_idx];
    assign transp_hit = (pix_idx == IDX_W'(TRANSP_IDX));

    // ---- Stage 1: palette read, transparency key, valid ----
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1    <= 1'b0;
            rgb_p1    <= '0;
            transp_p1 <= 1'b0;
        end else begin
            vld_p1 <= pix_valid_in;
            if (pix_valid_in) begin
                rgb_p1    <= transp_hit ? '0 : rd_rgb;
                transp_p1 <= transp_hit;
            end
        end
    end

    // ---- Stage 2: flash override, registered outputs held between valid pixels ----
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_valid_out <= 1'b0;
            rgb_p2        <= '0;
            transparent   <= 1'b0;
        end else begin
            pix_valid_out <= vld_p1;
            if (vld_p1) begin
                rgb_p2      <= apply_flash(rgb_p1, flash_on, transp_p1);
                transparent <= transp_p1;
            end
        end
    end

    assign {red, green, blue} = rgb_p2;

endmodule

// File: tb/tb_sprite_palette_engine.sv
// Self-checking bench for sprite_palette_engine: directed vector table,
// hand-written flash/reset sequences, and randomized traffic against a model.
module tb_sprite_palette_engine;

    localparam int IDX_W        = 3;
    localparam int NUM_PAL      = 4;
    localparam int COLOR_W      = 4;
    localparam int PAL_W        = 2;
    localparam int FLASH_FRAMES = 16;
    localparam int FLASH_PERIOD = 2;

    logic               Clk;
    logic               Reset_n;
    logic               wr_en;
    logic [PAL_W-1:0]   wr_pal;
    logic [IDX_W-1:0]   wr_idx;
    logic [11:0]        wr_rgb;
    logic               pix_valid_in;
    logic [PAL_W-1:0]   pix_pal;
    logic [IDX_W-1:0]   pix_idx;
    logic               frame_tick;
    logic               flash_start;
    logic               pix_valid_out;
    logic [COLOR_W-1:0] red, green, blue;
    logic               transparent;
    logic               flash_active;

    sprite_palette_engine dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .wr_en        (wr_en),
        .wr_pal       (wr_pal),
        .wr_idx       (wr_idx),
        .wr_rgb       (wr_rgb),
        .pix_valid_in (pix_valid_in),
        .pix_pal      (pix_pal),
        .pix_idx      (pix_idx),
        .frame_tick   (frame_tick),
        .flash_start  (flash_start),
        .pix_valid_out(pix_valid_out),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .transparent  (transparent),
        .flash_active (flash_active)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    logic [11:0] mdl_pal [NUM_PAL][8];
    bit          fl_active;
    int          fl_ticks;

    typedef struct {
        bit          v;
        logic [11:0] rgb;
        bit          tr;
    } res_t;

    res_t        pend;
    logic [11:0] held_rgb;
    bit          held_tr;

    bit          tab_chk;
    bit          tab_v;
    logic [11:0] tab_rgb;
    bit          tab_tr;

    task automatic model_reset();
        logic [11:0] defs [8];
        defs = '{12'h0E0, 12'h000, 12'h877, 12'hDAA, 12'h910, 12'h080, 12'h544, 12'hEEE};
        for (int p = 0; p < NUM_PAL; p++)
            for (int e = 0; e < 8; e++)
                mdl_pal[p][e] = defs[e];
        fl_active = 0;
        fl_ticks  = 0;
        pend.v    = 0;
        pend.rgb  = '0;
        pend.tr   = 0;
        held_rgb  = '0;
        held_tr   = 0;
        tab_chk   = 0;
    endtask

    task automatic set_idle();
        wr_en = 0; wr_pal = '0; wr_idx = '0; wr_rgb = '0;
        pix_valid_in = 0; pix_pal = '0; pix_idx = '0;
        frame_tick = 0; flash_start = 0;
    endtask

    // One clock: predict this cycle's lookup, advance, then compare what emerges.
    task automatic cycle(input bit tchk = 0, input bit tv = 0,
                         input logic [11:0] trgb = '0, input bit ttr = 0);
        res_t r;
        r.v = pix_valid_in;
        if (pix_idx == 0) begin
            r.rgb = '0;
            r.tr  = 1;
        end else begin
            r.rgb = mdl_pal[pix_pal][pix_idx];
            r.tr  = 0;
        end
        if (wr_en) mdl_pal[wr_pal][wr_idx] = wr_rgb;
        if (flash_start) begin
            fl_active = 1;
            fl_ticks  = 0;
        end else if (fl_active && frame_tick) begin
            fl_ticks++;
            if (fl_ticks >= FLASH_FRAMES) fl_active = 0;
        end
        if (fl_active && ((fl_ticks / FLASH_PERIOD) % 2 == 0) && !r.tr) r.rgb = 12'hFFF;

        @(posedge Clk);
        #1;
        if (pend.v) begin
            held_rgb = pend.rgb;
            held_tr  = pend.tr;
        end
        check("valid", pix_valid_out, pend.v);
        check("rgb", {red, green, blue}, held_rgb);
        check("transp", transparent, held_tr);
        check("flash_active", flash_active, fl_active);
        if (tab_chk) begin
            check("tab_valid", pix_valid_out, tab_v);
            check("tab_rgb", {red, green, blue}, tab_rgb);
            check("tab_transp", transparent, tab_tr);
        end
        tab_chk = tchk;
        tab_v   = tv;
        tab_rgb = trgb;
        tab_tr  = ttr;
        pend    = r;
    endtask

    task automatic apply_reset();
        Reset_n = 0;
        set_idle();
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1;
    endtask

    task automatic lookup(input logic [1:0] p, input logic [2:0] i);
        pix_valid_in = 1; pix_pal = p; pix_idx = i;
    endtask

    typedef struct {
        bit          we;
        logic [1:0]  wp;
        logic [2:0]  wi;
        logic [11:0] wd;
        bit          pv;
        logic [1:0]  pp;
        logic [2:0]  pi;
        bit          ev;
        logic [11:0] ergb;
        bit          etr;
    } vec_t;

    vec_t tab [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mask;

        tab[0]  = '{0, 0, 0, 12'h000, 1, 0, 3, 1, 12'hDAA, 0};
        tab[1]  = '{0, 0, 0, 12'h000, 1, 0, 4, 1, 12'h910, 0};
        tab[2]  = '{0, 0, 0, 12'h000, 1, 0, 7, 1, 12'hEEE, 0};
        tab[3]  = '{1, 2, 5, 12'hABC, 1, 2, 5, 1, 12'h080, 0};
        tab[4]  = '{0, 0, 0, 12'h000, 1, 2, 5, 1, 12'hABC, 0};
        tab[5]  = '{0, 0, 0, 12'h000, 1, 0, 0, 1, 12'h000, 1};
        tab[6]  = '{0, 0, 0, 12'h000, 1, 1, 0, 1, 12'h000, 1};
        tab[7]  = '{0, 0, 0, 12'h000, 1, 2, 0, 1, 12'h000, 1};
        tab[8]  = '{0, 0, 0, 12'h000, 1, 3, 0, 1, 12'h000, 1};
        tab[9]  = '{0, 0, 0, 12'h000, 1, 1, 1, 1, 12'h000, 0};
        tab[10] = '{0, 0, 0, 12'h000, 1, 3, 6, 1, 12'h544, 0};
        tab[11] = '{0, 0, 0, 12'h000, 0, 0, 0, 0, 12'h544, 0};

        // Reset state
        Reset_n = 0;
        set_idle();
        model_reset();
        #12;
        check("rst_valid", pix_valid_out, 1'b0);
        check("rst_rgb", {red, green, blue}, 12'h000);
        check("rst_transp", transparent, 1'b0);
        check("rst_flash", flash_active, 1'b0);
        @(posedge Clk);
        #1;
        Reset_n = 1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            wr_en = tab[i].we; wr_pal = tab[i].wp; wr_idx = tab[i].wi; wr_rgb = tab[i].wd;
            pix_valid_in = tab[i].pv; pix_pal = tab[i].pp; pix_idx = tab[i].pi;
            frame_tick = 0; flash_start = 0;
            cycle(1, tab[i].ev, tab[i].ergb, tab[i].etr);
        end
        set_idle();
        cycle();
        cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            wr_en        = ($urandom_range(0, 9) < 3);
            wr_pal       = 2'($urandom);
            wr_idx       = 3'($urandom);
            wr_rgb       = 12'($urandom);
            pix_valid_in = ($urandom_range(0, 9) < 7);
            pix_pal      = 2'($urandom);
            pix_idx      = 3'($urandom);
            frame_tick   = ($urandom_range(0, 4) == 0);
            flash_start  = ($urandom_range(0, 39) == 0);
            cycle();
        end
        set_idle();
        cycle();
        cycle();

        // Full flash sequence: white in frames 0-1, 4-5, 8-9, 12-13
        apply_reset();
        mask = 16'b0011_0011_0011_0011;
        flash_start = 1;
        cycle();
        flash_start = 0;
        for (int f = 0; f < 16; f++) begin
            lookup(0, 2);
            cycle();
            set_idle();
            cycle();
            check("flash_pix", {red, green, blue}, mask[f] ? 12'hFFF : 12'h877);
            frame_tick = 1;
            cycle();
            frame_tick = 0;
        end
        check("flash_end", flash_active, 1'b0);
        cycle();

        // Restart coincident with tick 10
        apply_reset();
        flash_start = 1;
        cycle();
        flash_start = 0;
        for (int t = 1; t < 10; t++) begin
            frame_tick = 1;
            cycle();
            frame_tick = 0;
            cycle();
        end
        frame_tick = 1;
        flash_start = 1;
        cycle();
        set_idle();
        lookup(0, 2);
        cycle();
        set_idle();
        cycle();
        check("restart_on", {red, green, blue}, 12'hFFF);
        for (int t = 0; t < 15; t++) begin
            frame_tick = 1;
            cycle();
            frame_tick = 0;
        end
        check("restart_reload", flash_active, 1'b1);
        frame_tick = 1;
        cycle();
        frame_tick = 0;
        check("restart_end", flash_active, 1'b0);

        // Reset in the middle of a lookup burst and an active flash
        apply_reset();
        wr_en = 1; wr_pal = 1; wr_idx = 3; wr_rgb = 12'h111;
        cycle();
        set_idle();
        flash_start = 1;
        cycle();
        set_idle();
        lookup(1, 3);
        cycle();
        lookup(0, 4);
        cycle();
        lookup(0, 7);
        cycle();
        #2;
        Reset_n = 0;
        #1;
        check("midrst_valid", pix_valid_out, 1'b0);
        check("midrst_rgb", {red, green, blue}, 12'h000);
        check("midrst_transp", transparent, 1'b0);
        check("midrst_flash", flash_active, 1'b0);
        set_idle();
        model_reset();
        @(posedge Clk);
        #1;
        Reset_n = 1;
        cycle();
        cycle();
        lookup(1, 3);
        cycle();
        set_idle();
        cycle();
        check("midrst_default", {red, green, blue}, 12'hDAA);
        cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
